// File: rtl/treg_pkg.sv
// Shared constants for the multi-mode toggle register: MODE encodings and
// the legal WIDTH range.
package treg_pkg;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_TOG  = 3'b010;
    localparam logic [2:0] M_CLR  = 3'b011;
    localparam logic [2:0] M_SET  = 3'b100;
    localparam logic [2:0] M_UP   = 3'b101;
    localparam logic [2:0] M_DOWN = 3'b110;
    localparam logic [2:0] M_SHL  = 3'b111;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/tff_cell.sv
// Single toggle flop with a synchronous reset to a per-instance reset bit.
module tff_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic t_i,
    output logic q_o
);

    logic q_q;

    // Toggle when t_i is high; reset loads the instance's reset bit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_q ^ t_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/treg_mode.sv
// Parametrised multi-mode toggle register. Every mode is reduced to a
// per-bit toggle vector feeding a bank of toggle flops; count modes use
// prefix-AND carry/borrow chains and raise a wrap pulse plus a sticky flag.
module treg_mode
    import treg_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             clr_ovf_i,
    output logic [WIDTH-1:0] out_o,
    output logic             wrap_o,
    output logic             ovf_o
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("treg_mode: WIDTH out of legal range");
        end
    endgenerate

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] t_d;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic             wrap_d;
    logic             wrap_q;
    logic             ovf_d;
    logic             ovf_q;

    // Carry (up) and borrow (down) prefix-AND chains.
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] &  state_q[i-1];
            dn_t[i] = dn_t[i-1] & ~state_q[i-1];
        end
    end

    // Toggle-vector mux: each mode expressed as the bits that must flip.
    // Gated by en_i so a disabled cycle flips nothing.
    always_comb begin
        t_d = '0;
        if (en_i) begin
            case (mode_i)
                M_HOLD:  t_d = '0;
                M_LOAD:  t_d = state_q ^ in_i;
                M_TOG:   t_d = in_i;
                M_CLR:   t_d = state_q & in_i;
                M_SET:   t_d = ~state_q & in_i;
                M_UP:    t_d = up_t;
                M_DOWN:  t_d = dn_t;
                M_SHL:   t_d = state_q ^ {state_q[WIDTH-2:0], in_i[0]};
                default: t_d = '0;
            endcase
        end
    end

    // Wrap happens when counting up from all-ones or down from zero.
    always_comb begin
        wrap_d = en_i && (((mode_i == M_UP)   && (&state_q)) ||
                          ((mode_i == M_DOWN) && (state_q == '0)));
        ovf_d  = ovf_q;
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (wrap_d) begin
            ovf_d = 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_cell
            tff_cell #(
                .RESET_BIT(RESET_VAL[g])
            ) u_cell (
                .clk_i  (clk_i),
                .reset_i(reset_i),
                .t_i    (t_d[g]),
                .q_o    (state_q[g])
            );
        end
    endgenerate

    // Wrap pulse and sticky overflow flag; set beats clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_o  = state_q;
    assign wrap_o = wrap_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_treg_mode.sv
// Directed bench for treg_mode at WIDTH=4 (RESET_VAL=5), WIDTH=2, WIDTH=32.
module tb_treg_mode;
  import treg_pkg::*;

  logic        clk;
  logic        reset;
  logic        en;
  logic [2:0]  mode;
  logic        clr_ovf;
  logic [3:0]  in4;
  logic [1:0]  in2;
  logic [31:0] in32;
  logic [3:0]  out4;
  logic [1:0]  out2;
  logic [31:0] out32;
  logic        wrap4, wrap2, wrap32;
  logic        ovf4, ovf2, ovf32;

  int n_vec;
  int n_miss;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  treg_mode #(.WIDTH(4), .RESET_VAL(4'h5)) dut4 (
    .clk_i(clk), .reset_i(reset), .en_i(en), .mode_i(mode), .in_i(in4),
    .clr_ovf_i(clr_ovf), .out_o(out4), .wrap_o(wrap4), .ovf_o(ovf4)
  );

  treg_mode #(.WIDTH(2), .RESET_VAL(2'h0)) dut2 (
    .clk_i(clk), .reset_i(reset), .en_i(en), .mode_i(mode), .in_i(in2),
    .clr_ovf_i(clr_ovf), .out_o(out2), .wrap_o(wrap2), .ovf_o(ovf2)
  );

  treg_mode #(.WIDTH(32), .RESET_VAL(32'h0)) dut32 (
    .clk_i(clk), .reset_i(reset), .en_i(en), .mode_i(mode), .in_i(in32),
    .clr_ovf_i(clr_ovf), .out_o(out32), .wrap_o(wrap32), .ovf_o(ovf32)
  );

  // scoreboard check
  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: advance one edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] o, input logic w, input logic v);
    check_vec({tag, ".out"}, {28'h0, out4}, {28'h0, o});
    check_vec({tag, ".wrap"}, {31'h0, wrap4}, {31'h0, w});
    check_vec({tag, ".ovf"}, {31'h0, ovf4}, {31'h0, v});
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    reset = 1'b1; en = 1'b1; mode = M_UP; clr_ovf = 1'b0;
    in4 = '0; in2 = '0; in32 = '0;

    // reset held two cycles with UP requested
    step(); chk4("rst0", 4'h5, 1'b0, 1'b0);
    step(); chk4("rst1", 4'h5, 1'b0, 1'b0);
    reset = 1'b0;
    step(); chk4("rel", 4'h6, 1'b0, 1'b0);

    // up-count wrap
    mode = M_LOAD; in4 = 4'hE;
    step(); chk4("ld_e", 4'hE, 1'b0, 1'b0);
    mode = M_UP;
    step(); chk4("up_f", 4'hF, 1'b0, 1'b0);
    step(); chk4("up_0", 4'h0, 1'b1, 1'b1);
    step(); chk4("up_1", 4'h1, 1'b0, 1'b1);

    // down-count wrap colliding with clear
    mode = M_LOAD; in4 = 4'h0;
    step(); chk4("ld_0", 4'h0, 1'b0, 1'b1);
    mode = M_DOWN; clr_ovf = 1'b1;
    step(); chk4("dn_f", 4'hF, 1'b1, 1'b1);
    step(); chk4("dn_e", 4'hE, 1'b0, 1'b0);
    clr_ovf = 1'b0;

    // mask modes
    mode = M_LOAD; in4 = 4'b1010;
    step(); chk4("ld_a", 4'b1010, 1'b0, 1'b0);
    mode = M_TOG; in4 = 4'b0110;
    step(); chk4("tog", 4'b1100, 1'b0, 1'b0);
    mode = M_SET; in4 = 4'b0001;
    step(); chk4("set", 4'b1101, 1'b0, 1'b0);
    mode = M_CLR; in4 = 4'b1000;
    step(); chk4("clr", 4'b0101, 1'b0, 1'b0);

    // shift and enable
    mode = M_LOAD; in4 = 4'b0011;
    step(); chk4("ld_3", 4'b0011, 1'b0, 1'b0);
    mode = M_SHL; in4 = 4'b0001;
    step(); chk4("shl1", 4'b0111, 1'b0, 1'b0);
    en = 1'b0; in4 = 4'b0000;
    step(); chk4("hold0", 4'b0111, 1'b0, 1'b0);
    step(); chk4("hold1", 4'b0111, 1'b0, 1'b0);
    en = 1'b1;
    step(); chk4("shl0", 4'b1110, 1'b0, 1'b0);

    // parameter sweep: WIDTH=2 and WIDTH=32
    reset = 1'b1;
    step();
    check_vec("w2.rst", {30'h0, out2}, 32'h0);
    check_vec("w32.rst", out32, 32'h0);
    reset = 1'b0;
    mode = M_LOAD; in2 = 2'b11; in32 = 32'hFFFF_FFFF;
    step();
    check_vec("w2.ld", {30'h0, out2}, 32'h3);
    check_vec("w32.ld", out32, 32'hFFFF_FFFF);
    mode = M_UP;
    step();
    check_vec("w2.wrap_out", {30'h0, out2}, 32'h0);
    check_vec("w2.wrap", {31'h0, wrap2}, 32'h1);
    check_vec("w32.wrap_out", out32, 32'h0);
    check_vec("w32.wrap", {31'h0, wrap32}, 32'h1);
    check_vec("w32.ovf", {31'h0, ovf32}, 32'h1);
    mode = M_LOAD; in32 = 32'h0000_FFFF;
    step();
    check_vec("w32.ld_ffff", out32, 32'h0000_FFFF);
    mode = M_UP;
    step();
    check_vec("w32.carry", out32, 32'h0001_0000);
    check_vec("w32.nowrap", {31'h0, wrap32}, 32'h0);
    check_vec("w32.ovf_keep", {31'h0, ovf32}, 32'h1);

    // clear overflow while disabled
    en = 1'b0; clr_ovf = 1'b1;
    step();
    check_vec("w32.en0_out", out32, 32'h0001_0000);
    check_vec("w32.en0_ovf", {31'h0, ovf32}, 32'h0);
    check_vec("w32.en0_wrap", {31'h0, wrap32}, 32'h0);
    clr_ovf = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
